// File: rtl/timer0_interrupt_unit.sv
// Timer0 interrupt arbiter: turns TOV0/OCF0 flags into a CPU request,
// then clears the serviced flag through a one-cycle TIFR write-back.
module timer0_interrupt_unit #(
  parameter logic [7:0] COMP_VECTOR = 8'h14,
  parameter logic [7:0] OVF_VECTOR  = 8'h16
) (
  input  logic       sysClock,
  input  logic       rst,
  input  logic [7:0] TIFR_in,
  input  logic [7:0] TIMSK_in,
  input  logic       global_int_enable,
  input  logic       irq_ack,
  output logic       irq_req,
  output logic [7:0] irq_vector,
  output logic [7:0] TIFR_out,
  output logic       TIFR_write_enable,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CLEAR,
    HOLDOFF
  } state_t;

  state_t     state;
  state_t     state_n;
  logic       src_comp;
  logic       src_comp_n;
  logic       irq_req_n;
  logic [7:0] vec_n;
  logic [7:0] tout_n;
  logic       we_n;
  logic [1:0] pending;
  logic       src_pending;
  logic       unused_mask;

  assign pending     = TIFR_in[1:0] & TIMSK_in[1:0]
                     & {2{global_int_enable}};
  assign src_pending = src_comp ? pending[1] : pending[0];
  assign unused_mask = ^TIMSK_in[7:2];

  // Next state and next registered outputs; default is "no request".
  always_comb begin
    state_n    = state;
    src_comp_n = src_comp;
    irq_req_n  = 1'b0;
    vec_n      = 8'h00;
    tout_n     = 8'h00;
    we_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending != 2'b00) begin
          state_n    = REQ;
          src_comp_n = pending[1];
          irq_req_n  = 1'b1;
          vec_n      = pending[1] ? COMP_VECTOR : OVF_VECTOR;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_n = CLEAR;
          we_n    = 1'b1;
          tout_n  = TIFR_in;
          if (src_comp) tout_n[1] = 1'b0;
          else          tout_n[0] = 1'b0;
        end else if (!src_pending) begin
          state_n = IDLE;
        end else begin
          irq_req_n = 1'b1;
          vec_n     = irq_vector;
        end
      end
      CLEAR:   state_n = HOLDOFF;
      HOLDOFF: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, latched source and all outputs registered together.
  always_ff @(posedge sysClock) begin
    if (rst) begin
      state             <= IDLE;
      src_comp          <= 1'b0;
      irq_req           <= 1'b0;
      irq_vector        <= 8'h00;
      TIFR_out          <= 8'h00;
      TIFR_write_enable <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_n;
      src_comp          <= src_comp_n;
      irq_req           <= irq_req_n;
      irq_vector        <= vec_n;
      TIFR_out          <= tout_n;
      TIFR_write_enable <= we_n;
      busy              <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_timer0_interrupt_unit.sv
// Bench for timer0_interrupt_unit: directed scenarios plus random traffic,
// scored by a schedule-based reference model and an event monitor.
module tb_timer0_interrupt_unit;

  localparam logic [7:0] COMPV = 8'h14;
  localparam logic [7:0] OVFV  = 8'h16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tifr;
  logic [7:0] timsk;
  logic       gie;
  logic       ack;
  logic       irq_req;
  logic [7:0] irq_vector;
  logic [7:0] tifr_out;
  logic       tifr_we;
  logic       busy;

  typedef struct packed {
    logic       req;
    logic [7:0] vec;
    logic       we;
    logic [7:0] dat;
    logic       busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } ev_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   done = 0;
  ev_t  q[$];
  obs_t sched[int];
  obs_t last_exp = '0;
  int   cur = -1;
  int   lock = 0;

  timer0_interrupt_unit #(
    .COMP_VECTOR(COMPV),
    .OVF_VECTOR (OVFV)
  ) dut (
    .sysClock         (clk),
    .rst              (rst),
    .TIFR_in          (tifr),
    .TIMSK_in         (timsk),
    .global_int_enable(gie),
    .irq_ack          (ack),
    .irq_req          (irq_req),
    .irq_vector       (irq_vector),
    .TIFR_out         (tifr_out),
    .TIFR_write_enable(tifr_we),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: inputs seen in cycle t schedule the outputs of later cycles.
  task automatic model(input int t);
    logic [1:0] p;
    obs_t       nxt;
    obs_t       o;
    logic [7:0] d;
    ev_t        e;
    p = tifr[1:0] & timsk[1:0] & {2{gie}};
    if (rst) begin
      for (int k = t + 1; k <= t + 3; k++)
        if (sched.exists(k)) sched.delete(k);
      sched[t+1] = '0;
      cur  = -1;
      lock = t + 1;
    end else if (cur >= 0) begin
      if (ack) begin
        d      = tifr;
        d[cur] = 1'b0;
        o      = '0;
        o.we   = 1'b1;
        o.dat  = d;
        o.busy = 1'b1;
        sched[t+1] = o;
        o      = '0;
        o.busy = 1'b1;
        sched[t+2] = o;
        sched[t+3] = '0;
        lock = t + 3;
        cur  = -1;
      end else if (!p[cur]) begin
        sched[t+1] = '0;
        lock = t + 1;
        cur  = -1;
      end
    end else if (t >= lock && p != 2'b00) begin
      cur    = p[1] ? 1 : 0;
      o      = '0;
      o.req  = 1'b1;
      o.vec  = p[1] ? COMPV : OVFV;
      o.busy = 1'b1;
      sched[t+1] = o;
    end
    nxt = last_exp;
    if (sched.exists(t + 1)) begin
      nxt = sched[t+1];
      sched.delete(t + 1);
    end
    if (nxt != last_exp) begin
      e.cyc = t + 1;
      e.v   = nxt;
      q.push_back(e);
    end
    last_exp = nxt;
  endtask

  task automatic c(input logic [7:0] f, input logic [7:0] m,
                   input logic i, input logic a, input logic r);
    tifr  = f;
    timsk = m;
    gie   = i;
    ack   = a;
    rst   = r;
    model(cyc);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every change of the DUT outputs must match the next expectation.
  initial begin : monitor
    obs_t dv;
    obs_t prev;
    ev_t  e;
    prev = '0;
    while (!done) begin
      @(negedge clk);
      if (cyc >= 1 && !done) begin
        dv = {irq_req, irq_vector, tifr_we, tifr_out, busy};
        if (cyc == 1) begin
          checks++;
          if (dv !== 19'h0) begin
            errors++;
            $display("FAIL reset_state cyc=%0d got=%h want=0", cyc, dv);
          end
        end else if (dv !== prev) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious cyc=%0d got=%h", cyc, dv);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.v !== dv) begin
              errors++;
              $display("FAIL event cyc=%0d got=%h want=%h@%0d",
                       cyc, dv, e.v, e.cyc);
            end
          end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
          checks++;
          errors++;
          e = q.pop_front();
          $display("FAIL missing cyc=%0d got=%h want=%h@%0d",
                   cyc, dv, e.v, e.cyc);
        end
        prev = dv;
      end
    end
  end

  initial begin : stim
    c(8'h00, 8'h00, 0, 0, 1);
    c(8'h00, 8'h00, 0, 0, 1);
    c(8'h00, 8'h00, 0, 0, 0);
    // single OVF request and acknowledge
    c(8'h01, 8'h01, 1, 0, 0);
    c(8'h01, 8'h01, 1, 0, 0);
    c(8'h01, 8'h01, 1, 1, 0);
    repeat (3) c(8'h00, 8'h01, 1, 0, 0);
    // COMP beats OVF, OVF follows after holdoff
    c(8'h03, 8'h03, 1, 0, 0);
    c(8'h03, 8'h03, 1, 1, 0);
    repeat (3) c(8'h01, 8'h03, 1, 0, 0);
    c(8'h01, 8'h03, 1, 1, 0);
    repeat (3) c(8'h00, 8'h03, 1, 0, 0);
    // masked by I-bit, then released
    repeat (2) c(8'h02, 8'h02, 0, 0, 0);
    c(8'h02, 8'h02, 1, 0, 0);
    c(8'h02, 8'h02, 1, 1, 0);
    repeat (3) c(8'h00, 8'h00, 1, 0, 0);
    // withdraw, then ack coinciding with withdraw
    c(8'h01, 8'h01, 1, 0, 0);
    c(8'h01, 8'h00, 1, 0, 0);
    c(8'h01, 8'h00, 1, 0, 0);
    c(8'h01, 8'h01, 1, 0, 0);
    c(8'hA5, 8'h00, 1, 1, 0);
    repeat (3) c(8'h00, 8'h00, 1, 0, 0);
    // reset during write-back, stray ack while idle
    c(8'h02, 8'h02, 1, 0, 0);
    c(8'h02, 8'h02, 1, 1, 0);
    c(8'h02, 8'h02, 1, 0, 1);
    c(8'h00, 8'h00, 1, 1, 0);
    c(8'h00, 8'h00, 1, 0, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      c(8'($urandom),
        8'($urandom) | (($urandom_range(0, 3) != 0) ? 8'h03 : 8'h00),
        ($urandom_range(0, 9) != 0),
        ($urandom_range(0, 3) == 0),
        ($urandom_range(0, 79) == 0));
    end
    repeat (6) c(8'h00, 8'h00, 0, 0, 0);
    @(negedge clk);
    done = 1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
